// File: rtl/axi_4_lite_slv_regbank_pkg.sv
// Shared definitions for the AXI4-Lite slave register bank: response codes
// and the byte-address to register-index shift.
package axi_4_lite_slv_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of low address bits that select a byte inside one data word.
    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_4_lite_regfile.sv
// Register storage with byte-strobe write, read-only slot muxing and a
// combinational read port.
module axi_4_lite_regfile
    import axi_4_lite_slv_regbank_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_REGISTERS_NUMBER = 16,
    parameter int C_IDX_WIDTH = 6,
    parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           wr_en,
    input  logic [C_IDX_WIDTH-1:0]                         wr_idx,
    input  logic [C_AXI_DATA_WIDTH-1:0]                    wr_data,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]                  wr_strb,
    input  logic [C_IDX_WIDTH-1:0]                         rd_idx,
    output logic [C_AXI_DATA_WIDTH-1:0]                    rd_data,
    input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] regs_out
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

    logic [C_AXI_DATA_WIDTH-1:0] regs_q [C_REGISTERS_NUMBER];

    // Byte-lane write into writable slots; read-only slots are never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
                if (wr_idx == C_IDX_WIDTH'(i) && !C_RO_MASK[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Flat user view: read-only slots show the live user inputs.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
            regs_out[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] =
                C_RO_MASK[i] ? ro_in[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] : regs_q[i];
        end
    end

    // Read port; unmapped indices return zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
            if (rd_idx == C_IDX_WIDTH'(i)) begin
                rd_data = C_RO_MASK[i] ? ro_in[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] : regs_q[i];
            end
        end
    end

endmodule

// File: rtl/axi_4_lite_slv_regbank.sv
// AXI4-Lite slave register bank: independent AW/W capture with a single
// commit point, B/R backpressure, SLVERR on unmapped or read-only targets.
module axi_4_lite_slv_regbank
    import axi_4_lite_slv_regbank_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int C_REGISTERS_NUMBER = 16,
    parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0
) (
    input  logic                                           S_AXI_ACLK,
    input  logic                                           S_AXI_ARESETN,
    input  logic                                           S_AXI_AWVALID,
    output logic                                           S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]                    S_AXI_AWADDR,
    input  logic [2:0]                                     S_AXI_AWPROT,
    input  logic                                           S_AXI_WVALID,
    output logic                                           S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]                    S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]                  S_AXI_WSTRB,
    output logic                                           S_AXI_BVALID,
    input  logic                                           S_AXI_BREADY,
    output logic [1:0]                                     S_AXI_BRESP,
    input  logic                                           S_AXI_ARVALID,
    output logic                                           S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]                    S_AXI_ARADDR,
    input  logic [2:0]                                     S_AXI_ARPROT,
    output logic                                           S_AXI_RVALID,
    input  logic                                           S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]                    S_AXI_RDATA,
    output logic [1:0]                                     S_AXI_RRESP,
    output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] USR_REGS_OUT,
    input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] USR_RO_IN,
    output logic [C_REGISTERS_NUMBER-1:0]                  USR_WR_PULSE,
    output logic [C_REGISTERS_NUMBER-1:0]                  USR_RD_PULSE
);

    localparam int STRB_W   = C_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = addr_lsb(C_AXI_DATA_WIDTH);
    localparam int IDX_W    = C_AXI_ADDR_WIDTH - ADDR_LSB;

    logic                          awready_q, wready_q, bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          aw_held_q, w_held_q;
    logic [IDX_W-1:0]              aw_idx_q;
    logic [C_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]             w_strb_q;
    logic [C_REGISTERS_NUMBER-1:0] wr_pulse_q;

    logic                          arready_q, rvalid_q;
    logic [1:0]                    rresp_q;
    logic [C_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [C_REGISTERS_NUMBER-1:0] rd_sel_q, rd_pulse_q;

    logic                          aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [IDX_W-1:0]              awaddr_idx, ar_idx, wr_idx;
    logic [C_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
    logic [STRB_W-1:0]             wr_strb;
    logic [C_REGISTERS_NUMBER-1:0] wr_sel, ar_sel;
    logic                          unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign awaddr_idx = S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx     = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign aw_hs      = S_AXI_AWVALID && awready_q;
    assign w_hs       = S_AXI_WVALID && wready_q;
    assign ar_hs      = S_AXI_ARVALID && arready_q;
    // Address and data may each come from the hold register or this edge's handshake.
    assign commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx     = aw_held_q ? aw_idx_q : awaddr_idx;
    assign wr_data    = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb    = w_held_q ? w_strb_q : S_AXI_WSTRB;

    // Decode write target (mapped and writable) and read target (mapped).
    always_comb begin
        wr_sel = '0;
        ar_sel = '0;
        wr_ok  = 1'b0;
        for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_sel[i] = 1'b1;
                wr_ok     = !C_RO_MASK[i];
            end
            if (ar_idx == IDX_W'(i)) begin
                ar_sel[i] = 1'b1;
            end
        end
    end

    axi_4_lite_regfile #(
        .C_AXI_DATA_WIDTH  (C_AXI_DATA_WIDTH),
        .C_REGISTERS_NUMBER(C_REGISTERS_NUMBER),
        .C_IDX_WIDTH       (IDX_W),
        .C_RO_MASK         (C_RO_MASK)
    ) u_regfile (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .wr_en   (commit && wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_idx  (ar_idx),
        .rd_data (rd_data),
        .ro_in   (USR_RO_IN),
        .regs_out(USR_REGS_OUT)
    );

    // Write channel: capture AW/W independently, commit once both exist, hold B until accepted.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (commit) begin
                aw_held_q  <= 1'b0;
                w_held_q   <= 1'b0;
                awready_q  <= 1'b0;
                wready_q   <= 1'b0;
                bvalid_q   <= 1'b1;
                bresp_q    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                wr_pulse_q <= wr_ok ? wr_sel : '0;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= awaddr_idx;
                    awready_q <= 1'b0;
                end else if (!aw_held_q && !bvalid_q) begin
                    awready_q <= 1'b1;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                    wready_q <= 1'b0;
                end else if (!w_held_q && !bvalid_q) begin
                    wready_q <= 1'b1;
                end
                if (bvalid_q && S_AXI_BREADY) begin
                    bvalid_q  <= 1'b0;
                    bresp_q   <= RESP_OKAY;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                end
            end
        end
    end

    // Read channel: sample the regfile on AR, hold R until accepted, then clear.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_sel_q   <= '0;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            if (ar_hs) begin
                rvalid_q  <= 1'b1;
                arready_q <= 1'b0;
                rdata_q   <= rd_data;
                rresp_q   <= (|ar_sel) ? RESP_OKAY : RESP_SLVERR;
                rd_sel_q  <= ar_sel;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q   <= 1'b0;
                arready_q  <= 1'b1;
                rdata_q    <= '0;
                rresp_q    <= RESP_OKAY;
                rd_pulse_q <= rd_sel_q;
            end else if (!rvalid_q) begin
                arready_q <= 1'b1;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign USR_WR_PULSE  = wr_pulse_q;
    assign USR_RD_PULSE  = rd_pulse_q;

endmodule
